// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: I2S BCLK/LRCLK generator and PISO sequencer with a one-pair holding buffer
module i2s_tx_ctrl #(
   parameter int WD      = 24,
   parameter int SLOT_W  = 32,
   parameter int CLK_DIV = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          valid_i,
   input  logic [WD-1:0] left_i,
   input  logic [WD-1:0] right_i,
   output logic          ready_o,
   output logic          underrun_o,
   output logic          busy_o,
   output logic          bclk_o,
   output logic          lrclk_o,
   output logic          piso_en_o,
   output logic          piso_wren_o,
   output logic [WD-1:0] piso_pdata_o
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(SLOT_W);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   logic [1:0]    state;
   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt;
   logic [BW-1:0] bit_nxt;
   logic          full;
   logic [WD-1:0] hold_l;
   logic [WD-1:0] hold_r;
   logic [WD-1:0] frm_r;
   logic          tc;
   logic          fall;
   logic          stop;
   logic          load;
   logic          load_l;
   // Tick decode: the left sample goes straight from the holding buffer into the PISO,
   // so only the right half of the frame needs to be kept until the right-slot load.
   always_comb begin
      tc           = (state != IDLE) && (div_cnt == DW'(CLK_DIV - 1));
      fall         = tc && bclk_o;
      bit_nxt      = (bit_cnt == BW'(SLOT_W - 1)) ? '0 : bit_cnt + 1'b1;
      stop         = fall && (state == DRAIN) && !en_i && (bit_nxt == '0) && lrclk_o;
      piso_en_o    = fall && !stop;
      load         = piso_en_o && (bit_nxt == BW'(1));
      load_l       = load && !lrclk_o;
      piso_wren_o  = piso_en_o && !load;
      piso_pdata_o = !load ? '0 : lrclk_o ? frm_r : full ? hold_l : '0;
      underrun_o   = load_l && !full;
      ready_o      = !full;
      busy_o       = state != IDLE;
   end
   // BCLK divider, slot bit counter, LRCLK and run/drain/idle sequencing
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= BW'(SLOT_W - 1);
         bclk_o  <= 1'b0;
         lrclk_o <= 1'b1;
      end else if (state == IDLE || stop) begin
         state   <= (state == IDLE && en_i) ? RUN : IDLE;
         div_cnt <= '0;
         bit_cnt <= BW'(SLOT_W - 1);
         bclk_o  <= 1'b0;
         lrclk_o <= 1'b1;
      end else begin
         state   <= en_i ? RUN : DRAIN;
         div_cnt <= tc ? '0 : div_cnt + 1'b1;
         bclk_o  <= bclk_o ^ tc;
         if (fall) begin
            bit_cnt <= bit_nxt;
            lrclk_o <= lrclk_o ^ (bit_nxt == '0);
         end
      end
   end
   // Holding buffer accept, and its pop into the frame at the left-slot load tick
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         full   <= 1'b0;
         hold_l <= '0;
         hold_r <= '0;
         frm_r  <= '0;
      end else begin
         if (valid_i && !full) begin
            hold_l <= left_i;
            hold_r <= right_i;
            full   <= 1'b1;
         end
         if (load_l) begin
            frm_r <= full ? hold_r : '0;
            if (full) full <= 1'b0;
         end
      end
   end
endmodule
